item_memory_mport_top: RTL

Multi-port successor to the two-port item-memory front end. It accepts `NumPorts` independent fetch streams and per-port mode selection (item-memory lookup or high-dimensional passthrough). A round-robin arbiter shares one external combinational item-memory lookup port among all lookup-mode streams, and each stream has its own hold FIFO toward the encoder. It sits between the data fetchers and the encoder and raises a global stall when the encoder pops an empty stream.

---
 rtl/item_memory_mport_top.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/item_memory_mport_top.sv
// Multi-port item-memory front end: round-robin shared lookup port, per-stream hold FIFOs.
// Optional per-port stall counters are built when ITEM_MEMORY_STALL_COUNTER_EN is defined.
module item_memory_mport_top #(
   parameter int unsigned HVDimension   = 512,
   parameter int unsigned NumPorts      = 4,
   parameter int unsigned ImAddrWidth   = 32,
   parameter int unsigned HoldFifoDepth = 2,
   parameter int unsigned StallCntWidth = 16
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [NumPorts-1:0]                       port_mode_i,
   input  logic [NumPorts-1:0]                       port_cim_i,
   input  logic                                      clr_i,
   input  logic                                      enable_i,
   output logic                                      stall_o,
   input  logic [NumPorts-1:0][ImAddrWidth-1:0]      lowdim_data_i,
   input  logic [NumPorts-1:0][HVDimension-1:0]      highdim_data_i,
   input  logic [NumPorts-1:0]                       data_valid_i,
   output logic [NumPorts-1:0]                       data_ready_o,
   output logic                                      im_req_o,
   output logic [ImAddrWidth-1:0]                    im_addr_o,
   output logic                                      im_cim_o,
   input  logic [HVDimension-1:0]                    im_data_i,
   output logic [NumPorts-1:0][HVDimension-1:0]      im_o,
   input  logic [NumPorts-1:0]                       im_pop_i,
   output logic [NumPorts-1:0][StallCntWidth-1:0]    stall_cnt_o
);

   localparam int unsigned PtrW = (HoldFifoDepth > 1) ? $clog2(HoldFifoDepth) : 1;
   localparam int unsigned CntW = $clog2(HoldFifoDepth + 1);
   localparam int unsigned RrW  = $clog2(NumPorts);

   logic [NumPorts-1:0] w_full;
   logic [NumPorts-1:0] w_empty;
   logic [NumPorts-1:0] w_elig;
   logic [NumPorts-1:0] w_grant_oh;
   logic                w_run;
   logic                w_grant_vld;
   logic [RrW-1:0]      w_grant_idx;
   logic [RrW-1:0]      r_rr_ptr;

   // rst_ni gates the push side so ready/req read 0 the moment reset is asserted.
   assign w_run  = enable_i & ~clr_i & rst_ni;
   assign w_elig = {NumPorts{w_run}} & data_valid_i & ~w_full & ~port_mode_i;

   always_comb begin
      int unsigned v_idx;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      v_idx       = 0;
      for (int unsigned k = 1; k <= NumPorts; k++) begin
         v_idx = (32'(r_rr_ptr) + k) % NumPorts;
         if (!w_grant_vld && w_elig[v_idx[RrW-1:0]]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = v_idx[RrW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr <= RrW'(NumPorts - 1);
      end else if (clr_i) begin
         r_rr_ptr <= RrW'(NumPorts - 1);
      end else if (w_grant_vld) begin
         r_rr_ptr <= w_grant_idx;
      end
   end

   assign w_grant_oh   = w_grant_vld ? (NumPorts'(1) << w_grant_idx) : '0;
   assign im_req_o     = w_grant_vld;
   assign im_addr_o    = w_grant_vld ? lowdim_data_i[w_grant_idx] : '0;
   assign im_cim_o     = w_grant_vld ? port_cim_i[w_grant_idx] : 1'b0;
   assign data_ready_o = (port_mode_i & ~w_full & {NumPorts{w_run}}) | w_grant_oh;
   assign stall_o      = |(im_pop_i & w_empty);

   for (genvar g = 0; g < NumPorts; g++) begin : g_port
      logic [HVDimension-1:0] r_mem [HoldFifoDepth];
      logic [PtrW-1:0]        r_rd_ptr;
      logic [PtrW-1:0]        r_wr_ptr;
      logic [CntW-1:0]        r_count;
      logic                   w_push;
      logic                   w_pop;
      logic [HVDimension-1:0] w_wdata;

      assign w_full[g]  = (r_count == CntW'(HoldFifoDepth));
      assign w_empty[g] = (r_count == '0);
      // Ready already excludes full and clear, so a push never collides with those.
      assign w_push     = data_valid_i[g] & data_ready_o[g];
      assign w_pop      = im_pop_i[g] & ~w_empty[g] & ~clr_i;
      assign w_wdata    = port_mode_i[g] ? highdim_data_i[g] : im_data_i;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else if (clr_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= (r_wr_ptr == PtrW'(HoldFifoDepth - 1)) ? '0 : r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= (r_rd_ptr == PtrW'(HoldFifoDepth - 1)) ? '0 : r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CntW'(1);
               2'b01:   r_count <= r_count - CntW'(1);
               default: r_count <= r_count;
            endcase
         end
      end

      always_ff @(posedge clk_i) begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
         end
      end

      assign im_o[g] = w_empty[g] ? '0 : r_mem[r_rd_ptr];

`ifdef ITEM_MEMORY_STALL_COUNTER_EN
      logic [StallCntWidth-1:0] r_stall_cnt;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_stall_cnt <= '0;
         end else if (clr_i) begin
            r_stall_cnt <= '0;
         end else if (im_pop_i[g] && w_empty[g] && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + StallCntWidth'(1);
         end
      end

      assign stall_cnt_o[g] = r_stall_cnt;
`else
      assign stall_cnt_o[g] = '0;
`endif
   end

endmodule
